// File: rtl/uart_tx_fifo.sv
// UART transmitter with an input FIFO, configurable data width,
// runtime parity/stop selection and back-to-back frame output.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   data_in/valid     character offered by the producer
//   data_ready        FIFO can accept (not full)
//   baudrate_reg      bit period minus 1, in clk cycles
//   parity_mode       00 none, 01 even, 10 odd, 11 mark
//   stop2             0 = one stop bit, 1 = two stop bits
//   TxD               serial line, idles high
//   tx_busy           frame in progress or FIFO non-empty
//   tx_done           one-cycle pulse after the last stop bit period
//   fifo_level        entries currently queued
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int BAUD_W     = 14
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [DATA_BITS-1:0]              data_in,
    input  logic                              data_valid,
    output logic                              data_ready,
    input  logic [BAUD_W-1:0]                 baudrate_reg,
    input  logic [1:0]                        parity_mode,
    input  logic                              stop2,
    output logic                              TxD,
    output logic                              tx_busy,
    output logic                              tx_done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int BIT_W = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // FIFO storage and bookkeeping
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [LVL_W-1:0]     level_q;

    logic full;
    logic empty;
    logic push;
    logic pop;

    // Transmit state
    state_t               state_q;
    state_t               state_d;
    logic [BAUD_W-1:0]    baud_cnt_q;
    logic [BAUD_W-1:0]    baud_q;
    logic [BIT_W-1:0]     bit_cnt_q;
    logic                 stop_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_en_q;
    logic                 par_bit_q;
    logic                 stop2_q;
    logic                 done_q;
    logic                 done_d;

    logic                 bit_end;
    logic                 last_data;
    logic                 last_stop;
    logic [DATA_BITS-1:0] head;
    logic                 par_calc;

    assign full  = (level_q == LVL_W'(FIFO_DEPTH));
    assign empty = (level_q == '0);
    // A full FIFO refuses data even if a pop frees a slot this cycle.
    assign push  = data_valid && !full;
    assign head  = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    assign bit_end   = (baud_cnt_q == baud_q);
    assign last_data = (bit_cnt_q == BIT_W'(DATA_BITS - 1));
    assign last_stop = (stop_cnt_q == stop2_q);

    always_comb begin
        par_calc = 1'b0;
        case (parity_mode)
            2'b01:   par_calc = ^head;
            2'b10:   par_calc = ~^head;
            2'b11:   par_calc = 1'b1;
            default: par_calc = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; pop only ever happens on a frame start.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    state_d = S_START;
                    pop     = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end && last_data) begin
                    state_d = par_en_q ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end && last_stop) begin
                    done_d = 1'b1;
                    if (!empty) begin
                        state_d = S_START;
                        pop     = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: frame config is latched at frame start only.
    always_ff @(posedge clk) begin
        if (reset) begin
            baud_cnt_q <= '0;
            baud_q     <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            stop2_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= done_d;
            if (pop) begin
                shift_q    <= head;
                baud_q     <= baudrate_reg;
                par_en_q   <= (parity_mode != 2'b00);
                par_bit_q  <= par_calc;
                stop2_q    <= stop2;
                baud_cnt_q <= '0;
                bit_cnt_q  <= '0;
                stop_cnt_q <= 1'b0;
            end else if (state_q != S_IDLE) begin
                if (bit_end) begin
                    baud_cnt_q <= '0;
                    if (state_q == S_DATA) begin
                        shift_q   <= {1'b0, shift_q[DATA_BITS-1:1]};
                        bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                    end
                    if (state_q == S_STOP) begin
                        stop_cnt_q <= 1'b1;
                    end
                end else begin
                    baud_cnt_q <= baud_cnt_q + BAUD_W'(1);
                end
            end
        end
    end

    // Output logic
    always_comb begin
        TxD = 1'b1;
        unique case (state_q)
            S_IDLE:   TxD = 1'b1;
            S_START:  TxD = 1'b0;
            S_DATA:   TxD = shift_q[0];
            S_PARITY: TxD = par_bit_q;
            S_STOP:   TxD = 1'b1;
            default:  TxD = 1'b1;
        endcase
    end

    assign tx_busy    = (state_q != S_IDLE) || !empty;
    assign data_ready = !full;
    assign tx_done    = done_q;
    assign fifo_level = level_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: cycle-level waveform-queue
// model, directed frame checks and a randomized soak.
module tb_uart_tx_fifo;

    localparam int DB = 8;
    localparam int FD = 4;
    localparam int BW = 14;
    localparam int LW = 3;

    logic          clk;
    logic          reset;
    logic [DB-1:0] data_in;
    logic          data_valid;
    logic          data_ready;
    logic [BW-1:0] baudrate_reg;
    logic [1:0]    parity_mode;
    logic          stop2;
    logic          TxD;
    logic          tx_busy;
    logic          tx_done;
    logic [LW-1:0] fifo_level;

    uart_tx_fifo #(
        .DATA_BITS (DB),
        .FIFO_DEPTH(FD),
        .BAUD_W    (BW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .baudrate_reg(baudrate_reg),
        .parity_mode (parity_mode),
        .stop2       (stop2),
        .TxD         (TxD),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .fifo_level  (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;
    bit chk_en = 0;

    // Model: queued words, and the per-cycle TxD values of the
    // frame on the line (front = the current cycle).
    logic [DB-1:0] mq[$];
    bit            wave[$];
    bit            m_done = 0;
    bit            junk;

    function automatic void chk(string name, logic [31:0] act,
                                logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endfunction

    function automatic void build(logic [DB-1:0] w, int baud,
                                  logic [1:0] pm, logic s2);
        bit fb[$];
        fb.push_back(1'b0);
        for (int i = 0; i < DB; i++) fb.push_back(w[i]);
        if (pm == 2'b01) fb.push_back(^w);
        if (pm == 2'b10) fb.push_back(~^w);
        if (pm == 2'b11) fb.push_back(1'b1);
        fb.push_back(1'b1);
        if (s2) fb.push_back(1'b1);
        foreach (fb[k])
            for (int r = 0; r <= baud; r++) wave.push_back(fb[k]);
    endfunction

    always @(posedge clk) begin
        bit acc;
        if (reset) begin
            mq.delete();
            wave.delete();
            m_done = 0;
        end else begin
            acc = data_valid && (mq.size() < FD);
            m_done = 0;
            if (wave.size() > 0) begin
                junk = wave.pop_front();
                if (wave.size() == 0) m_done = 1;
            end
            if (wave.size() == 0 && mq.size() > 0)
                build(mq.pop_front(), int'(baudrate_reg),
                      parity_mode, stop2);
            if (acc) mq.push_back(data_in);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("txd", 32'(TxD),
                wave.size() > 0 ? 32'(wave[0]) : 32'd1);
            chk("tx_done", 32'(tx_done), 32'(m_done));
            chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
            chk("data_ready", 32'(data_ready),
                32'(mq.size() < FD));
            chk("tx_busy", 32'(tx_busy),
                32'(wave.size() > 0 || mq.size() > 0));
            if (tx_done === 1'b1) done_cnt++;
        end
    end

    task automatic push(input logic [DB-1:0] d);
        @(negedge clk);
        data_in = d;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (tx_busy !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("idle_timeout", 32'(tx_busy), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    // Samples each bit mid-period starting at the start bit and
    // records the cycle index of tx_done.
    task automatic capture(input int baud, input int nbits,
                           input int newbaud,
                           output logic [15:0] bits,
                           output int done_idx);
        int n = 0;
        int bi;
        bits = '0;
        done_idx = -1;
        while (TxD !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (TxD !== 1'b0) begin
            chk("start_timeout", 32'(TxD), 32'd0);
            return;
        end
        for (int i = 0; i < nbits * (baud + 1) + 6; i++) begin
            if (i == 2 && newbaud >= 0) baudrate_reg = BW'(newbaud);
            bi = i / (baud + 1);
            if (i % (baud + 1) == baud / 2 && bi < 16) bits[bi] = TxD;
            if (tx_done === 1'b1 && done_idx < 0) done_idx = i;
            @(negedge clk);
        end
    endtask

    logic [15:0] bits;
    int          didx;

    initial begin
        reset = 1'b1;
        data_valid = 1'b0;
        data_in = '0;
        baudrate_reg = BW'(3);
        parity_mode = 2'b00;
        stop2 = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1;
        chk("rst_txd", 32'(TxD), 32'd1);
        chk("rst_ready", 32'(data_ready), 32'd1);
        chk("rst_busy", 32'(tx_busy), 32'd0);
        chk("rst_done", 32'(tx_done), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // 8N1, 4 cycles per bit
        push(8'hA5);
        capture(3, 10, -1, bits, didx);
        chk("a5_none_bits", 32'(bits[9:0]), 32'h34A);
        chk("a5_none_done", 32'(didx), 32'd40);
        wait_idle();

        parity_mode = 2'b01;
        push(8'hA5);
        capture(3, 11, -1, bits, didx);
        chk("a5_even_bits", 32'(bits[10:0]), 32'h54A);
        chk("a5_even_done", 32'(didx), 32'd44);
        wait_idle();

        parity_mode = 2'b10;
        push(8'hA5);
        capture(3, 11, -1, bits, didx);
        chk("a5_odd_bits", 32'(bits[10:0]), 32'h74A);
        chk("a5_odd_done", 32'(didx), 32'd44);
        wait_idle();

        stop2 = 1'b1;
        push(8'hA5);
        capture(3, 12, -1, bits, didx);
        chk("a5_odd2_bits", 32'(bits[11:0]), 32'hF4A);
        chk("a5_odd2_done", 32'(didx), 32'd48);
        wait_idle();

        // Mark parity, one cycle per bit, divisor changed mid-frame
        baudrate_reg = BW'(0);
        parity_mode = 2'b11;
        stop2 = 1'b0;
        push(8'hFF);
        capture(0, 11, 9, bits, didx);
        chk("mark_bits", 32'(bits[10:0]), 32'h7FE);
        chk("mark_done", 32'(didx), 32'd11);
        wait_idle();

        // Back-to-back frames from a burst of pushes
        baudrate_reg = BW'(1);
        parity_mode = 2'b00;
        done_cnt = 0;
        @(negedge clk);
        data_valid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            data_in = DB'(i);
            @(negedge clk);
        end
        data_valid = 1'b0;
        wait_idle();
        chk("burst_done_cnt", 32'(done_cnt), 32'd5);

        // Hold valid high across a full FIFO and its pops
        baudrate_reg = BW'(3);
        data_valid = 1'b1;
        for (int i = 0; i < 120; i++) begin
            data_in = DB'($urandom);
            @(negedge clk);
        end
        data_valid = 1'b0;
        wait_idle();

        // Reset during the third data bit with two words queued
        done_cnt = 0;
        @(negedge clk);
        data_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_in = DB'(8'h30 + i);
            @(negedge clk);
        end
        data_valid = 1'b0;
        while (TxD !== 1'b0) @(negedge clk);
        repeat (13) @(negedge clk);
        chk("pre_rst_level", 32'(fifo_level), 32'd2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_txd", 32'(TxD), 32'd1);
        chk("mid_rst_level", 32'(fifo_level), 32'd0);
        repeat (60) @(negedge clk);
        chk("mid_rst_nodone", 32'(done_cnt), 32'd0);

        // Randomized soak
        for (int i = 0; i < 3000; i++) begin
            data_valid = ($urandom_range(0, 2) != 0);
            data_in = DB'($urandom);
            if ($urandom_range(0, 150) == 0) begin
                baudrate_reg = BW'($urandom_range(0, 3));
                parity_mode = 2'($urandom);
                stop2 = 1'($urandom);
            end
            reset = ($urandom_range(0, 700) == 0);
            @(negedge clk);
        end
        reset = 1'b0;
        data_valid = 1'b0;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
